// File: rtl/dcache_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_port_arbiter_if
// Purpose  : Load/store request, cache request and tagged response bundle
//            for the shared data-cache port.
// Revision : 1.0
// ============================================================================
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic                  ld_req_vld;
    logic [ADDR_W-1:0]     ld_req_addr;
    logic [TAG_W-1:0]      ld_req_tag;
    logic                  ld_req_rdy;

    logic                  st_req_vld;
    logic [ADDR_W-1:0]     st_req_addr;
    logic [DATA_W-1:0]     st_req_data;
    logic [DATA_W/8-1:0]   st_req_mask;
    logic                  st_req_rdy;

    logic                  sdq_full;
    logic                  flush;

    logic                  dc_req_vld;
    logic                  dc_req_we;
    logic [ADDR_W-1:0]     dc_req_addr;
    logic [DATA_W-1:0]     dc_req_data;
    logic [DATA_W/8-1:0]   dc_req_mask;
    logic                  dc_req_rdy;

    logic                  dc_resp_vld;
    logic [DATA_W-1:0]     dc_resp_data;

    logic                  ld_resp_vld;
    logic [TAG_W-1:0]      ld_resp_tag;
    logic [DATA_W-1:0]     ld_resp_data;

    modport master (
        input  ld_req_vld, ld_req_addr, ld_req_tag,
        output ld_req_rdy,
        input  st_req_vld, st_req_addr, st_req_data, st_req_mask,
        output st_req_rdy,
        input  sdq_full, flush,
        output dc_req_vld, dc_req_we, dc_req_addr, dc_req_data, dc_req_mask,
        input  dc_req_rdy,
        input  dc_resp_vld, dc_resp_data,
        output ld_resp_vld, ld_resp_tag, ld_resp_data
    );

    modport slave (
        output ld_req_vld, ld_req_addr, ld_req_tag,
        input  ld_req_rdy,
        output st_req_vld, st_req_addr, st_req_data, st_req_mask,
        input  st_req_rdy,
        output sdq_full, flush,
        input  dc_req_vld, dc_req_we, dc_req_addr, dc_req_data, dc_req_mask,
        output dc_req_rdy,
        output dc_resp_vld, dc_resp_data,
        input  ld_resp_vld, ld_resp_tag, ld_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dcache_port_arbiter
// Purpose  : Shares one data-cache request slot between load issue and
//            committed-store drain; returns tagged, flush-squashable loads.
// Revision : 1.0
// ============================================================================
module dcache_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 4,
    parameter int MAX_LD_OUT   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    dcache_port_arbiter_if.master   bus
);
    localparam int C_MASK_W = DATA_W / 8;
    localparam int C_PTR_W  = $clog2(MAX_LD_OUT);
    localparam int C_CNT_W  = C_PTR_W + 1;
    localparam int C_SC_W   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_LD    = 2'd1,
        SLOT_ST    = 2'd2
    } slot_state_t;

    slot_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic [C_MASK_W-1:0]  r_mask;
    logic [C_SC_W-1:0]    r_starve;

    logic [TAG_W-1:0]     r_fifo_tag [MAX_LD_OUT];
    logic [MAX_LD_OUT-1:0] r_fifo_kill;
    logic [C_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic                 r_resp_vld;
    logic [TAG_W-1:0]     r_resp_tag;
    logic [DATA_W-1:0]    r_resp_data;

    logic w_slot_vld, w_slot_free, w_ld_elig, w_force_st;
    logic w_grant_st, w_grant_ld, w_drop, w_push, w_pop;

    assign w_slot_vld  = (r_state != SLOT_EMPTY);
    assign w_slot_free = !w_slot_vld || bus.dc_req_rdy;
    assign w_ld_elig   = bus.ld_req_vld && !bus.flush &&
                         (r_cnt < C_CNT_W'(MAX_LD_OUT));
    assign w_force_st  = bus.sdq_full || (r_starve >= C_SC_W'(STARVE_LIMIT));
    assign w_grant_st  = w_slot_free && bus.st_req_vld && (w_force_st || !w_ld_elig);
    assign w_grant_ld  = w_slot_free && !w_grant_st && w_ld_elig;

    // A flushed load still waiting in the slot is withdrawn along with its tag.
    assign w_drop      = bus.flush && (r_state == SLOT_LD) && !bus.dc_req_rdy;
    assign w_push      = w_grant_ld;
    assign w_pop       = bus.dc_resp_vld && (r_cnt != '0);
    assign w_cnt_nxt   = r_cnt + C_CNT_W'(w_push) - C_CNT_W'(w_pop) - C_CNT_W'(w_drop);

    assign bus.ld_req_rdy   = w_grant_ld;
    assign bus.st_req_rdy   = w_grant_st;
    assign bus.dc_req_vld   = w_slot_vld;
    assign bus.dc_req_we    = (r_state == SLOT_ST);
    assign bus.dc_req_addr  = r_addr;
    assign bus.dc_req_data  = r_data;
    assign bus.dc_req_mask  = r_mask;
    assign bus.ld_resp_vld  = r_resp_vld;
    assign bus.ld_resp_tag  = r_resp_tag;
    assign bus.ld_resp_data = r_resp_data;

    always_comb begin
        w_state_nxt = r_state;
        if (w_drop) begin
            w_state_nxt = SLOT_EMPTY;
        end else if (w_slot_free) begin
            if (w_grant_st)      w_state_nxt = SLOT_ST;
            else if (w_grant_ld) w_state_nxt = SLOT_LD;
            else                 w_state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drop) begin
                r_addr <= '0;
                r_data <= '0;
                r_mask <= '0;
            end else if (w_slot_free) begin
                if (w_grant_st) begin
                    r_addr <= bus.st_req_addr;
                    r_data <= bus.st_req_data;
                    r_mask <= bus.st_req_mask;
                end else if (w_grant_ld) begin
                    r_addr <= bus.ld_req_addr;
                    r_data <= '0;
                    r_mask <= '0;
                end else begin
                    r_addr <= '0;
                    r_data <= '0;
                    r_mask <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant_st || !bus.st_req_vld) begin
            r_starve <= '0;
        end else if (w_grant_ld && (r_starve < C_SC_W'(STARVE_LIMIT))) begin
            r_starve <= r_starve + C_SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_fifo_kill <= '0;
            for (int i = 0; i < MAX_LD_OUT; i++) r_fifo_tag[i] <= '0;
        end else begin
            if (bus.flush) r_fifo_kill <= '1;
            if (w_push) begin
                r_fifo_tag[r_wr_ptr]  <= bus.ld_req_tag;
                r_fifo_kill[r_wr_ptr] <= bus.flush;
                r_wr_ptr              <= r_wr_ptr + C_PTR_W'(1);
            end else if (w_drop) begin
                r_wr_ptr <= r_wr_ptr - C_PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            r_cnt <= w_cnt_nxt;
        end
    end

    // A flush coinciding with the response squashes it as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_vld  <= 1'b0;
            r_resp_tag  <= '0;
            r_resp_data <= '0;
        end else begin
            r_resp_vld <= w_pop && !(r_fifo_kill[r_rd_ptr] || bus.flush);
            if (w_pop) begin
                r_resp_tag  <= r_fifo_tag[r_rd_ptr];
                r_resp_data <= bus.dc_resp_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_port_arbiter
// Purpose  : Directed stimulus with a queue-based reference model checked
//            every cycle, plus literal expectations for key scenarios.
// Revision : 1.0
// ============================================================================
module tb_dcache_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) bus ();

    dcache_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TAG_W(4), .MAX_LD_OUT(4), .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: slot contents, outstanding tags in request order
    bit           m_slot_v, m_slot_we;
    logic [31:0]  m_slot_addr, m_slot_data;
    logic [3:0]   m_slot_mask;
    logic [3:0]   m_tag [$];
    bit           m_kill [$];
    int           m_starve;
    bit           m_resp_v;
    logic [3:0]   m_resp_tag;
    logic [31:0]  m_resp_data;

    always @(negedge clk) begin
        bit free, ld_ok, force_st, st_win, ld_win, k;
        if (rst) begin
            m_slot_v = 0; m_slot_we = 0; m_starve = 0; m_resp_v = 0;
            m_tag.delete(); m_kill.delete();
        end else begin
            free     = !m_slot_v || bus.dc_req_rdy;
            ld_ok    = bus.ld_req_vld && !bus.flush && (m_tag.size() < 4);
            force_st = bus.sdq_full || (m_starve >= 4);
            st_win   = free && bus.st_req_vld && (force_st || !ld_ok);
            ld_win   = free && !st_win && ld_ok;

            chk("dc_req_vld", bus.dc_req_vld, m_slot_v);
            if (m_slot_v) begin
                chk("dc_req_we",   bus.dc_req_we,   m_slot_we);
                chk("dc_req_addr", bus.dc_req_addr, m_slot_addr);
                chk("dc_req_data", bus.dc_req_data, m_slot_data);
                chk("dc_req_mask", bus.dc_req_mask, m_slot_mask);
            end
            chk("ld_req_rdy",  bus.ld_req_rdy,  ld_win);
            chk("st_req_rdy",  bus.st_req_rdy,  st_win);
            chk("ld_resp_vld", bus.ld_resp_vld, m_resp_v);
            if (m_resp_v) begin
                chk("ld_resp_tag",  bus.ld_resp_tag,  m_resp_tag);
                chk("ld_resp_data", bus.ld_resp_data, m_resp_data);
            end

            m_resp_v = 0;
            if (bus.dc_resp_vld && m_tag.size() > 0) begin
                k           = m_kill.pop_front() || bus.flush;
                m_resp_tag  = m_tag.pop_front();
                m_resp_v    = !k;
                m_resp_data = bus.dc_resp_data;
            end
            if (bus.flush) foreach (m_kill[i]) m_kill[i] = 1;
            if (bus.flush && m_slot_v && !m_slot_we && !bus.dc_req_rdy) begin
                m_slot_v = 0;
                void'(m_tag.pop_back());
                void'(m_kill.pop_back());
            end else if (free) begin
                if (st_win) begin
                    m_slot_v = 1; m_slot_we = 1; m_slot_addr = bus.st_req_addr;
                    m_slot_data = bus.st_req_data; m_slot_mask = bus.st_req_mask;
                end else if (ld_win) begin
                    m_slot_v = 1; m_slot_we = 0; m_slot_addr = bus.ld_req_addr;
                    m_slot_data = 0; m_slot_mask = 0;
                    m_tag.push_back(bus.ld_req_tag);
                    m_kill.push_back(bus.flush);
                end else begin
                    m_slot_v = 0;
                end
            end
            if (st_win || !bus.st_req_vld) m_starve = 0;
            else if (ld_win)               m_starve = (m_starve < 4) ? m_starve + 1 : 4;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_req_vld = 0; bus.ld_req_addr = 0; bus.ld_req_tag = 0;
        bus.st_req_vld = 0; bus.st_req_addr = 0; bus.st_req_data = 0; bus.st_req_mask = 0;
        bus.sdq_full = 0; bus.flush = 0; bus.dc_req_rdy = 1;
        bus.dc_resp_vld = 0; bus.dc_resp_data = 0;
    endtask

    // Returns responses for every load the cache has already accepted.
    task automatic drain();
        idle();
        for (int j = 0; j < 12; j++) begin
            bus.dc_resp_vld  = (m_tag.size() > ((m_slot_v && !m_slot_we) ? 1 : 0));
            bus.dc_resp_data = 32'hC0DE_0000 + j;
            @(negedge clk);
            cyc();
        end
        bus.dc_resp_vld = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (3) cyc();
        rst = 0;

        // reset state
        @(negedge clk);
        chk("rst_dc_req_vld",  bus.dc_req_vld,  1'b0);
        chk("rst_dc_req_addr", bus.dc_req_addr, 32'h0);
        chk("rst_ld_resp_vld", bus.ld_resp_vld, 1'b0);
        chk("rst_ld_resp_tag", bus.ld_resp_tag, 4'h0);
        cyc();

        // load only
        bus.ld_req_vld = 1; bus.ld_req_tag = 4'd3; bus.ld_req_addr = 32'h100;
        @(negedge clk); chk("ld_only_rdy", bus.ld_req_rdy, 1'b1); cyc();
        bus.ld_req_vld = 0;
        @(negedge clk);
        chk("ld_only_vld",  bus.dc_req_vld,  1'b1);
        chk("ld_only_we",   bus.dc_req_we,   1'b0);
        chk("ld_only_addr", bus.dc_req_addr, 32'h100);
        cyc();
        bus.dc_resp_vld = 1; bus.dc_resp_data = 32'hDEAD;
        @(negedge clk); cyc();
        bus.dc_resp_vld = 0;
        @(negedge clk);
        chk("ld_only_resp_vld",  bus.ld_resp_vld,  1'b1);
        chk("ld_only_resp_tag",  bus.ld_resp_tag,  4'd3);
        chk("ld_only_resp_data", bus.ld_resp_data, 32'hDEAD);
        cyc();

        // starvation: four loads then one store, repeating
        idle();
        bus.ld_req_vld = 1; bus.st_req_vld = 1;
        bus.st_req_addr = 32'h500; bus.st_req_data = 32'h5555_AAAA; bus.st_req_mask = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            bus.ld_req_tag   = 4'(c);
            bus.ld_req_addr  = 32'h1000 + 32'(c * 4);
            bus.dc_resp_vld  = (c >= 3);
            bus.dc_resp_data = 32'hBEEF_0000 + 32'(c);
            @(negedge clk);
            chk("starve_st_rdy", bus.st_req_rdy, (c == 5 || c == 10));
            chk("starve_ld_rdy", bus.ld_req_rdy, !(c == 5 || c == 10));
            if (c == 6) chk("starve_we", bus.dc_req_we, 1'b1);
            cyc();
        end
        drain();

        // SDQ full overrides load priority
        bus.ld_req_vld = 1; bus.ld_req_tag = 4'd9; bus.ld_req_addr = 32'h180;
        bus.st_req_vld = 1; bus.st_req_addr = 32'h600; bus.st_req_data = 32'h66; bus.st_req_mask = 4'h1;
        bus.sdq_full = 1;
        @(negedge clk);
        chk("sdq_full_st_rdy", bus.st_req_rdy, 1'b1);
        chk("sdq_full_ld_rdy", bus.ld_req_rdy, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        chk("sdq_full_we",   bus.dc_req_we,   1'b1);
        chk("sdq_full_addr", bus.dc_req_addr, 32'h600);
        cyc();
        drain();

        // backpressure with a store in the slot
        bus.st_req_vld = 1; bus.st_req_addr = 32'h200; bus.st_req_data = 32'h1234_5678; bus.st_req_mask = 4'hF;
        @(negedge clk); chk("bp_grant", bus.st_req_rdy, 1'b1); cyc();
        bus.dc_req_rdy = 0; bus.st_req_addr = 32'h300; bus.st_req_data = 32'h9; bus.st_req_mask = 4'h3;
        bus.ld_req_vld = 1; bus.ld_req_tag = 4'd2; bus.ld_req_addr = 32'h140;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_addr",   bus.dc_req_addr, 32'h200);
            chk("bp_data",   bus.dc_req_data, 32'h1234_5678);
            chk("bp_st_rdy", bus.st_req_rdy,  1'b0);
            chk("bp_ld_rdy", bus.ld_req_rdy,  1'b0);
            cyc();
        end
        bus.dc_req_rdy = 1;
        @(negedge clk);
        chk("bp_release_ld", bus.ld_req_rdy, 1'b1);
        chk("bp_release_st", bus.st_req_rdy, 1'b0);
        cyc();
        drain();

        // outstanding load limit
        bus.ld_req_vld = 1;
        for (int c = 1; c <= 7; c++) begin
            bus.ld_req_tag  = 4'(c + 8);
            bus.ld_req_addr = 32'h2000 + 32'(c * 4);
            bus.dc_resp_vld = (c == 6); bus.dc_resp_data = 32'h600D;
            @(negedge clk);
            chk("limit_ld_rdy", bus.ld_req_rdy, (c <= 4 || c == 7));
            cyc();
        end
        drain();

        // flush: two loads outstanding, one stalled in the slot, store waiting
        bus.ld_req_vld = 1;
        for (int c = 0; c < 3; c++) begin
            bus.ld_req_tag = 4'(5 + c); bus.ld_req_addr = 32'h700 + 32'(c * 4);
            @(negedge clk); cyc();
        end
        bus.ld_req_vld = 0; bus.dc_req_rdy = 0;
        @(negedge clk); cyc();
        bus.flush = 1; bus.st_req_vld = 1; bus.st_req_addr = 32'h800;
        bus.st_req_data = 32'hAA; bus.st_req_mask = 4'h3;
        @(negedge clk); chk("flush_st_rdy_stalled", bus.st_req_rdy, 1'b0); cyc();
        bus.flush = 0; bus.dc_req_rdy = 1;
        @(negedge clk);
        chk("flush_slot_dropped", bus.dc_req_vld, 1'b0);
        chk("flush_st_grant",     bus.st_req_rdy, 1'b1);
        cyc();
        bus.st_req_vld = 0; bus.dc_resp_vld = 1; bus.dc_resp_data = 32'h51;
        @(negedge clk);
        chk("flush_store_we",   bus.dc_req_we,   1'b1);
        chk("flush_store_addr", bus.dc_req_addr, 32'h800);
        cyc();
        bus.dc_resp_data = 32'h52;
        @(negedge clk); chk("flush_resp0_killed", bus.ld_resp_vld, 1'b0); cyc();
        bus.dc_resp_vld = 0;
        @(negedge clk); chk("flush_resp1_killed", bus.ld_resp_vld, 1'b0); cyc();
        bus.ld_req_vld = 1; bus.ld_req_tag = 4'hA; bus.ld_req_addr = 32'h880;
        @(negedge clk); chk("flush_after_ld_rdy", bus.ld_req_rdy, 1'b1); cyc();
        drain();

        // reset in the middle of a load
        bus.ld_req_vld = 1; bus.ld_req_tag = 4'hB; bus.ld_req_addr = 32'h900;
        @(negedge clk); cyc();
        bus.ld_req_vld = 0; bus.dc_req_rdy = 0;
        @(negedge clk); cyc();
        rst = 1;
        @(negedge clk); cyc();
        rst = 0; bus.dc_req_rdy = 1; bus.dc_resp_vld = 1; bus.dc_resp_data = 32'h77;
        @(negedge clk); chk("mid_rst_slot", bus.dc_req_vld, 1'b0); cyc();
        bus.dc_resp_vld = 0;
        @(negedge clk); chk("mid_rst_no_resp", bus.ld_resp_vld, 1'b0); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache request port between load issue (from the load queue) and committed-store drain (from the store data queue).
- Holds one registered request slot toward the cache.
- Arbitrates loads first, with store-starvation and SDQ-full overrides.
- Tracks outstanding loads in an in-order tag FIFO so responses return tagged, and squashes load responses on flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 4, load tag width (LDQ index)
- MAX_LD_OUT, 4, maximum outstanding loads; power of 2, ≥2
- STARVE_LIMIT, 4, consecutive lost store cycles before store priority is forced

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ld_req_vld  in  1  load request valid
- ld_req_addr  in  ADDR_W  load address
- ld_req_tag  in  TAG_W  load tag
- ld_req_rdy  out  1  load accepted when vld&rdy
- st_req_vld  in  1  committed store at SDQ head valid
- st_req_addr  in  ADDR_W  store address
- st_req_data  in  DATA_W  store data
- st_req_mask  in  DATA_W/8  byte enables
- st_req_rdy  out  1  store accepted (SDQ pops head) when vld&rdy
- sdq_full  in  1  SDQ full; forces store priority
- flush  in  1  pipeline flush; kills loads only
- dc_req_vld  out  1  cache request valid
- dc_req_we  out  1  1=store, 0=load
- dc_req_addr  out  ADDR_W  request address
- dc_req_data  out  DATA_W  store data (0 for loads)
- dc_req_mask  out  DATA_W/8  byte enables (0 for loads)
- dc_req_rdy  in  1  cache accepts slot when vld&rdy
- dc_resp_vld  in  1  load response, in request order
- dc_resp_data  in  DATA_W  load data
- ld_resp_vld  out  1  tagged load response valid
- ld_resp_tag  out  TAG_W  tag of response
- ld_resp_data  out  DATA_W  response data

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - all dc_req_* outputs 0
  - ld_resp_vld 0, ld_resp_tag 0, ld_resp_data 0
  - slot state SLOT_EMPTY, starve counter 0, tag FIFO empty, outstanding count 0
- A reset mid-transaction drops the slot and all outstanding tags without generating responses.
- Slot FSM states: SLOT_EMPTY, SLOT_LD, SLOT_ST.
  - slot_free = (state==SLOT_EMPTY) | (dc_req_vld & dc_req_rdy).
  - A grant loads the slot the next cycle (SLOT_LD or SLOT_ST); request-to-dc_req_vld latency is 1 cycle.
  - With no grant and the slot accepted, the FSM goes to SLOT_EMPTY.
  - With the slot not accepted, the slot is held and all dc_req_* outputs stay stable.
- Load eligibility: ld_req_vld & !flush & (ld_out_cnt < MAX_LD_OUT).
  - ld_out_cnt counts FIFO entries, including the load that currently occupies the slot.
- Arbitration, evaluated only when slot_free:
  - force_st = sdq_full | (starve_cnt >= STARVE_LIMIT)
  - if st_req_vld & (force_st | !ld_eligible): grant store
  - else if ld_eligible: grant load
- ld_req_rdy = slot_free & load granted; st_req_rdy = slot_free & store granted. Never both high in the same cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when st_req_vld and a load is granted.
  - Clears on a store grant or when !st_req_vld.
  - Otherwise holds.
- Tag FIFO, depth MAX_LD_OUT, entries {tag, killed}:
  - Pushed on each load grant.
  - Popped on each dc_resp_vld.
  - dc_resp_vld with the FIFO empty is a protocol error and is ignored.
- Responses are registered, 1 cycle after dc_resp_vld:
  - ld_resp_vld = !killed, with tag and data from the popped entry.
  - ld_resp_vld is 1 only for that cycle.
- Flush:
  - Sets killed on all FIFO entries and on a same-cycle push.
  - If the slot holds a load not accepted this cycle, the slot is dropped to SLOT_EMPTY and that FIFO entry is popped (tail retract).
  - A load accepted by the cache the same cycle stays in the FIFO, killed.
  - Stores are never dropped.
  - No grant is issued to a load during flush; a store may still be granted.
- Simultaneous push and pop: ld_out_cnt is unchanged; pointers wrap modulo MAX_LD_OUT.
- All arithmetic is unsigned; counter width is $clog2(MAX_LD_OUT)+1.

Test Plan:
- Load only: ld_req_vld=1, tag=3, addr=0x100, dc_req_rdy=1; response 2 cycles later with data 0xDEAD → next cycle dc_req_vld=1, we=0, addr=0x100; ld_resp_vld=1, tag=3, data 0xDEAD.
- Starvation: loads and st_req_vld held continuously, STARVE_LIMIT=4 → exactly 4 load grants, then 1 store grant (dc_req_we=1); pattern repeats.
- SDQ full: sdq_full=1 with ld and st both valid → store granted first cycle, ld_req_rdy=0.
- Backpressure: dc_req_rdy=0 for 5 cycles with a store in the slot → dc_req_* stable, st_req_rdy=0 and ld_req_rdy=0 throughout; one request accepted when rdy rises.
- Outstanding limit: 4 loads granted, no responses → ld_req_rdy=0 on the 5th; one response frees it the next cycle.
- Flush: 2 loads outstanding plus 1 load stalled in the slot, flush=1 → slot emptied, ld_out_cnt=2; both later responses produce ld_resp_vld=0; a concurrent store still drains.
